// File: rtl/decoder_scan.sv
// ============================================================================
// Module   : decoder_scan
// Brief    : Registered one-cold decoder with optional auto-scan mode
//            (scan logic compiled in when DECODER_SCAN_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_scan #(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                mode,
    input  logic [WIDTH-1:0]    in,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [2**WIDTH-1:0] out,
    output logic [WIDTH-1:0]    index,
    output logic                active,
    output logic                wrap
);

    localparam int OUTS = 2**WIDTH;
    localparam logic [OUTS-1:0] c_one = {{(OUTS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef DECODER_SCAN_EN
        S_SCAN   = 2'd2,
`endif
        S_DIRECT = 2'd1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [OUTS-1:0]   r_out;
    logic [OUTS-1:0]   w_out_nxt;
    logic [WIDTH-1:0]  r_index;
    logic [WIDTH-1:0]  w_index_nxt;
    logic              r_active;
    logic              w_active_nxt;
    logic              r_wrap;
    logic              w_wrap_nxt;

`ifdef DECODER_SCAN_EN
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [DWELL_W-1:0] r_len;
    logic [DWELL_W-1:0] w_len_nxt;
`else
    logic w_unused_scan_inputs;
    assign w_unused_scan_inputs = &{1'b0, mode, dwell};
`endif

    always_comb begin
        w_out_nxt    = '1;
        w_index_nxt  = '0;
        w_active_nxt = 1'b0;
        w_wrap_nxt   = 1'b0;
`ifdef DECODER_SCAN_EN
        w_cnt_nxt    = '0;
        w_len_nxt    = r_len;
`endif

        if (enable) begin
            w_state_nxt = S_IDLE;
        end
`ifdef DECODER_SCAN_EN
        else if (mode) begin
            w_state_nxt = S_SCAN;
        end
`endif
        else begin
            w_state_nxt = S_DIRECT;
        end

        case (w_state_nxt)
            S_DIRECT: begin
                w_index_nxt  = in;
                w_out_nxt    = ~(c_one << in);
                w_active_nxt = 1'b1;
            end
`ifdef DECODER_SCAN_EN
            S_SCAN: begin
                w_active_nxt = 1'b1;
                if (r_state != S_SCAN) begin
                    // Fresh entry always restarts the sweep; nothing resumes
                    w_index_nxt = '0;
                    w_len_nxt   = dwell;
                end else if (r_cnt == r_len) begin
                    w_index_nxt = r_index + 1'b1;
                    w_len_nxt   = dwell;
                    w_wrap_nxt  = &r_index;
                end else begin
                    w_index_nxt = r_index;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
                w_out_nxt = ~(c_one << w_index_nxt);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_out    <= '1;
            r_index  <= '0;
            r_active <= 1'b0;
            r_wrap   <= 1'b0;
`ifdef DECODER_SCAN_EN
            r_cnt    <= '0;
            r_len    <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_index  <= w_index_nxt;
            r_active <= w_active_nxt;
            r_wrap   <= w_wrap_nxt;
`ifdef DECODER_SCAN_EN
            r_cnt    <= w_cnt_nxt;
            r_len    <= w_len_nxt;
`endif
        end
    end

    assign out    = r_out;
    assign index  = r_index;
    assign active = r_active;
    assign wrap   = r_wrap;

endmodule

`default_nettype wire

// File: doc/decoder_scan.md
# decoder_scan

Parametrised, registered one-cold decoder: WIDTH select bits drive 2**WIDTH active-low outputs, gated by an active-low enable. It also has an auto-scan mode that steps the active output through every position with a programmable dwell time. It is the next generation of the 2-to-4 and 3-to-8 decoder family and is used for row/digit strobing, such as multiplexed displays and keypad scanning, where the team's plain combinational decoders would need an external counter.

## Interface
- WIDTH, 3: select width; output count OUTS = 2**WIDTH (derived, not overridable); legal range 1..6.
- DWELL_W, 8: width of the dwell input.
- clk  input  1: single clock; all state updates on the rising edge.
- rst  input  1: reset; synchronous, active-high.
- enable  input  1: active-low; 1 forces all outputs high (inactive), as in the rest of the decoder family.
- mode  input  1: 0 = direct decode of in; 1 = auto-scan.
- in  input  WIDTH: select value in direct mode; ignored in scan mode.
- dwell  input  DWELL_W: slot length in scan mode; each slot lasts dwell+1 cycles.
- out  output  OUTS: registered, one-cold, active-low; bit k low = position k active.
- index  output  WIDTH: registered index of the low bit of out; 0 when idle.
- active  output  1: 1 when exactly one bit of out is low.
- wrap  output  1: one-cycle pulse in scan mode when index returns from OUTS-1 to 0.

## Operation
- Reset values: out = all ones, index = 0, active = 0, wrap = 0, state = IDLE, dwell counter = 0.
- The block has three states: IDLE, DIRECT and SCAN. State is evaluated every cycle, and rst overrides everything.
- IDLE
  - Entered when enable = 1, from any state.
  - out = all ones, active = 0, index = 0, wrap = 0.
- DIRECT
  - Entered when enable = 0 and mode = 0.
  - Each cycle: out <= ~(1 << in), index <= in, active <= 1.
- SCAN
  - Entered when enable = 0 and mode = 1.
  - On entry from IDLE or DIRECT: index <= 0, out <= ~1, dwell counter cleared, and dwell is captured as the slot length.
  - The dwell counter increments every cycle. When it equals the captured length:
    - the counter clears;
    - index <= index+1, wrapping at OUTS-1 to 0;
    - out is updated to match the new index;
    - dwell is recaptured for the next slot.
  - Changing dwell mid-slot does not affect the current slot.
- Wrap: wrap = 1 for exactly the cycle in which out first shows index 0 after index OUTS-1. It is not asserted on SCAN entry.
- Dwell = 0: the index advances every cycle, and a full sweep takes OUTS cycles.
- Switching mode while enable = 0: takes effect at the next edge. SCAN to DIRECT shows decoded in; DIRECT to SCAN restarts at index 0.
- enable = 1 mid-scan: abandons the scan. A later return to SCAN always restarts at index 0 with no resume.
- At most one bit of out is low in every cycle, including across all transitions.

## Timing
- Latency is 1 cycle from (enable, mode, in) to out, index and active. There is no combinational path from inputs to outputs.
- Scan period is OUTS × (dwell+1) cycles when dwell is held constant.
- Reset is sampled at the clock edge. Asserting rst mid-scan yields reset values on the next edge. The first non-reset edge evaluates inputs normally.

## Configuration
- Macro: DECODER_SCAN_EN.
- When defined, the SCAN state, dwell counter, dwell capture and wrap logic are compiled in, behaving as above.
- When undefined:
  - mode and dwell are ignored;
  - only the IDLE and DIRECT states exist, so enable = 0 always decodes in;
  - wrap is tied to 0.
  - The port list is unchanged, keeping integrations identical.

## Test plan
- Reset with WIDTH = 3, enable = 1: all outputs are at reset values. Then set enable = 0, mode = 0, in = 5 → next edge out = 8'b11011111, index = 5, active = 1.
- Direct sweep of in = 0..7 with one value per cycle: out equals ~(1 << in) delayed one cycle. Then enable = 1 → out = 8'hFF, active = 0 on the next edge.
- Scan with dwell = 2: each index is held for 3 cycles, sequence 0..7 then 0. Wrap pulses once, in the cycle out = 8'b11111110 after index 7; the period is 24 cycles.
- Scan with dwell = 0: index advances every cycle. Change dwell to 3 mid-slot; the new length applies from the next slot only.
- Mid-scan events:
  - at index 4, set mode = 0 with in = 2 → out = 8'b11111011;
  - return to mode = 1 → restarts at index 0 with no wrap pulse;
  - assert rst at index 6 → reset values on the next edge.
- Build without DECODER_SCAN_EN: mode = 1, enable = 0, in = 3 → out = 8'b11110111, and wrap stays 0 for 100 cycles.
